// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the Water-Raid sprite compositor.
// VGA 640x480 timing in 50 MHz clocks, colour types, register map bases.
package sprite_compositor_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [3:0]  cidx_t;

  localparam int HACTIVE  = 1280;
  localparam int HS_START = 1312;
  localparam int HS_END   = 1504;
  localparam int HTOTAL   = 1600;

  localparam int VACTIVE  = 480;
  localparam int VS_START = 490;
  localparam int VS_END   = 492;
  localparam int VTOTAL   = 525;

  localparam cidx_t LAND_IDX  = 4'd1;
  localparam cidx_t WATER_IDX = 4'd2;

  localparam int BND_BASE = 0;
  localparam int PAL_BASE = 32;
  localparam int PAL_SIZE = 16;

  typedef struct packed {
    logic       en;
    logic [2:0] img;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_t;

  function automatic logic [7:0] rep4(
    input logic [3:0] n
  );
    return {n, n};
  endfunction

endpackage

// File: rtl/sprite_compositor_raster_timing.sv
// 1600x525 raster counters with undelayed sync/blank decode.
// swap marks the clk whose edge moves the counters to (0, VACTIVE).
module raster_timing
  import sprite_compositor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hs,
  output logic        vs,
  output logic        active,
  output logic        swap
);

  logic [10:0] h_n;
  logic [9:0]  v_n;
  logic        h_end;

  assign h_end = (hcount == 11'(HTOTAL - 1));

  always_comb begin
    h_n = hcount + 11'd1;
    v_n = vcount;
    if (h_end) begin
      h_n = '0;
      if (vcount == 10'(VTOTAL - 1))
        v_n = '0;
      else
        v_n = vcount + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_n;
      vcount <= v_n;
    end
  end

  assign hs = !((hcount >= 11'(HS_START)) &&
                (hcount <  11'(HS_END)));
  assign vs = !((vcount >= 10'(VS_START)) &&
                (vcount <  10'(VS_END)));
  assign active = (hcount < 11'(HACTIVE)) &&
                  (vcount < 10'(VACTIVE));
  assign swap = h_end && (vcount == 10'(VACTIVE - 1));

endmodule

// File: rtl/sprite_compositor.sv
// Sprite/river compositor: shadowed register banks, priority hit,
// four-stage pixel pipeline into the VGA pins.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_SPRITES    = 8,
  parameter int NUM_BOUNDARIES = 4,
  parameter int SPRITE_SIZE    = 32,
  parameter int NUM_IMAGES     = 8,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       writedata,
  output logic [$clog2(NUM_IMAGES*SPRITE_SIZE*SPRITE_SIZE)-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n,
  output logic              frame_irq
);

  localparam int SW     = $clog2(SPRITE_SIZE);
  localparam int ROM_AW = $clog2(NUM_IMAGES*SPRITE_SIZE*SPRITE_SIZE);
  localparam int SPR_BASE = BND_BASE + NUM_BOUNDARIES;
  localparam logic [10:0] SZ   = 11'(SPRITE_SIZE);
  localparam logic [10:0] HALF = 11'(SPRITE_SIZE / 2);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs;
  logic        vs;
  logic        active;
  logic        swap;

  raster_timing u_tim (
    .clk    (clk),
    .reset  (reset),
    .hcount (hcount),
    .vcount (vcount),
    .hs     (hs),
    .vs     (vs),
    .active (active),
    .swap   (swap)
  );

  logic        we;
  logic [31:0] a;

  assign we = chipselect && write;
  assign a  = 32'(address);

  logic [9:0] pend_b [NUM_BOUNDARIES];
  logic [9:0] act_b  [NUM_BOUNDARIES];
  sprite_t    pend_s [NUM_SPRITES];
  sprite_t    act_s  [NUM_SPRITES];
  rgb444_t    pal    [PAL_SIZE];

  // Nonblocking copy: a write landing on the swap edge stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_BOUNDARIES; k++) begin
        pend_b[k] <= '0;
        act_b[k]  <= '0;
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_s[i] <= '0;
        act_s[i]  <= '0;
      end
    end else begin
      if (swap) begin
        act_b <= pend_b;
        act_s <= pend_s;
      end
      for (int k = 0; k < NUM_BOUNDARIES; k++)
        if (we && a == 32'(BND_BASE + k))
          pend_b[k] <= writedata[9:0];
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (we && a == 32'(SPR_BASE + 2*i))
          pend_s[i].x <= writedata[9:0];
        if (we && a == 32'(SPR_BASE + 2*i + 1)) begin
          pend_s[i].y   <= writedata[9:0];
          pend_s[i].img <= writedata[14:12];
          pend_s[i].en  <= writedata[15];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < PAL_SIZE; n++)
        pal[n] <= '0;
    end else begin
      for (int n = 0; n < PAL_SIZE; n++)
        if (we && a == 32'(PAL_BASE + n))
          pal[n] <= writedata[11:0];
    end
  end

  logic [9:0]  col;
  logic [9:0]  row;
  logic [10:0] dx  [NUM_SPRITES];
  logic [10:0] dy  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit;

  assign col = hcount[10:1];
  assign row = vcount;

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i]  = 11'(col) - 11'(act_s[i].x) + HALF;
      dy[i]  = 11'(row) - 11'(act_s[i].y) + HALF;
      hit[i] = act_s[i].en && (dx[i] < SZ) && (dy[i] < SZ);
    end
  end

  logic              hit_any;
  logic [ROM_AW-1:0] addr_n;
  logic [31:0]       full;

  // Walk from the lowest priority up so slot 0 overrides last.
  always_comb begin
    hit_any = 1'b0;
    addr_n  = '0;
    full    = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        full = (32'(act_s[i].img) << (2*SW)) |
               (32'(dy[i][SW-1:0]) << SW) |
               32'(dx[i][SW-1:0]);
        addr_n = full[ROM_AW-1:0];
      end
    end
  end

  logic  par;
  cidx_t bg_n;

  always_comb begin
    par = 1'b0;
    for (int k = 0; k < NUM_BOUNDARIES; k++)
      if (act_b[k] != '0 && col >= act_b[k])
        par = ~par;
    bg_n = par ? WATER_IDX : LAND_IDX;
  end

  logic    s1_hit;
  cidx_t   s1_bg;
  logic    s2_hit;
  cidx_t   s2_bg;
  cidx_t   s3_idx;
  rgb444_t c;

  logic [3:0] hs_sr;
  logic [3:0] vs_sr;
  logic [3:0] act_sr;
  logic [3:0] pclk_sr;

  assign c = pal[s3_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      s1_hit    <= 1'b0;
      s1_bg     <= '0;
      s2_hit    <= 1'b0;
      s2_bg     <= '0;
      s3_idx    <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      hs_sr     <= '1;
      vs_sr     <= '1;
      act_sr    <= '0;
      pclk_sr   <= '0;
      frame_irq <= 1'b0;
    end else begin
      rom_addr <= addr_n;
      s1_hit   <= hit_any;
      s1_bg    <= bg_n;
      s2_hit   <= s1_hit;
      s2_bg    <= s1_bg;
      if (s2_hit && rom_q != 4'd0)
        s3_idx <= rom_q;
      else
        s3_idx <= s2_bg;
      if (act_sr[2]) begin
        VGA_R <= rep4(c[11:8]);
        VGA_G <= rep4(c[7:4]);
        VGA_B <= rep4(c[3:0]);
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
      hs_sr     <= {hs_sr[2:0], hs};
      vs_sr     <= {vs_sr[2:0], vs};
      act_sr    <= {act_sr[2:0], active};
      pclk_sr   <= {pclk_sr[2:0], hcount[0]};
      frame_irq <= swap;
    end
  end

  assign VGA_HS      = hs_sr[3];
  assign VGA_VS      = vs_sr[3];
  assign VGA_BLANK_n = act_sr[3];
  assign VGA_CLK     = pclk_sr[3];
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor; tracks the raster position itself
// and skips rows by overriding the line counter.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = '0;
  logic [15:0] writedata = '0;
  logic [12:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_n;
  logic        VGA_SYNC_n;
  logic        frame_irq;

  int checks = 0;
  int failures = 0;
  int mh = 0;
  int mv = 0;
  int rom_mode = 0;
  logic [9:0] fv = '0;

  localparam logic [23:0] LAND  = 24'h00AA00;
  localparam logic [23:0] WATER = 24'h0000BB;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] CYAN  = 24'h00FFFF;

  sprite_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n),
    .VGA_SYNC_n  (VGA_SYNC_n),
    .frame_irq   (frame_irq)
  );

  always #10 clk = ~clk;

  // Image 1 is solid index 4; image 5 has a transparent left strip in mode 1.
  function automatic logic [3:0] rom_fn(input logic [12:0] ra);
    if (ra[12:10] == 3'd1)
      return 4'd4;
    if (rom_mode == 1 && ra[12:10] == 3'd5 && ra[4:0] < 5'd4)
      return 4'd0;
    return 4'd3;
  endfunction

  always @(posedge clk)
    rom_q <= rom_fn(rom_addr);

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (mh == 1599) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    #1;
  endtask

  task automatic wait_to(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      failures++;
      $display("FAIL wait_to(%0d,%0d): timed out at (%0d,%0d)",
               h, v, mh, mv);
    end
  endtask

  task automatic wr(input logic [5:0] ad, input logic [15:0] d);
    chipselect = 1'b1;
    write = 1'b1;
    address = ad;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic jump_row(input int v);
    if (mh == 1599)
      tick();
    fv = 10'(v);
    force dut.u_tim.vcount = fv;
    tick();
    release dut.u_tim.vcount;
    mv = v;
  endtask

  task automatic do_swap(input string tag);
    jump_row(479);
    wait_to(1599, 479);
    checks++;
    if (frame_irq !== 1'b0) begin
      failures++;
      $display("FAIL %s irq_pre: got %b want 0", tag, frame_irq);
    end
    tick();
    checks++;
    if (frame_irq !== 1'b1) begin
      failures++;
      $display("FAIL %s irq_on: got %b want 1", tag, frame_irq);
    end
    tick();
    checks++;
    if (frame_irq !== 1'b0) begin
      failures++;
      $display("FAIL %s irq_off: got %b want 0", tag, frame_irq);
    end
  endtask

  task automatic test_reset();
    logic [31:0] o;
    int n;
    repeat (3) tick();
    o = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n,
         VGA_CLK, frame_irq, VGA_SYNC_n, 2'b00};
    checks++;
    if (o !== 32'h0000_00C0 || rom_addr !== 13'd0) begin
      failures++;
      $display("FAIL reset_hold: got %h/%h want 000000c0/0000", o, rom_addr);
    end
    reset = 1'b0;
    wr(6'h21, 16'h0ABC);
    wait_to(104, 0);
    checks++;
    if ({VGA_R, VGA_G, VGA_B, VGA_BLANK_n} !== {24'hAABBCC, 1'b1}) begin
      failures++;
      $display("FAIL reset_pre_rgb: got %h%h%h bn=%b want aabbcc bn=1",
               VGA_R, VGA_G, VGA_B, VGA_BLANK_n);
    end
    wait_to(1401, 0);
    checks++;
    if (VGA_HS !== 1'b0 || VGA_CLK !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_hs: got hs=%b clk=%b want 0 1",
               VGA_HS, VGA_CLK);
    end
    reset = 1'b1;
    #1;
    mh = 0;
    mv = 0;
    o = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n,
         VGA_CLK, frame_irq, VGA_SYNC_n, 2'b00};
    checks++;
    if (o !== 32'h0000_00C0 || rom_addr !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid: got %h/%h want 000000c0/0000", o, rom_addr);
    end
    tick();
    tick();
    reset = 1'b0;
    wait_to(104, 0);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      failures++;
      $display("FAIL reset_black: got %h%h%h want 000000",
               VGA_R, VGA_G, VGA_B);
    end
    n = 0;
    while (VGA_HS !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (mh != 1316 || mv != 0) begin
      failures++;
      $display("FAIL reset_first_hs: got (%0d,%0d) want (1316,0)", mh, mv);
    end
  endtask

  task automatic test_single();
    int cols [4] = '{83, 84, 115, 116};
    logic [23:0] want [4] = '{LAND, RED, RED, LAND};
    rom_mode = 0;
    wr(6'h23, 16'h0F00);
    wr(6'h21, 16'h00A0);
    wr(6'h22, 16'h000B);
    wr(6'd4, 16'd100);
    wr(6'd5, 16'hD064);
    do_swap("single");
    jump_row(83);
    wait_to(169, 84);
    checks++;
    if (rom_addr !== 13'd5120) begin
      failures++;
      $display("FAIL single_addr: got %0d want 5120", rom_addr);
    end
    jump_row(99);
    for (int i = 0; i < 4; i++) begin
      wait_to(2*cols[i] + 4, 100);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== want[i]) begin
        failures++;
        $display("FAIL single_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, want[i]);
      end
    end
  endtask

  task automatic test_priority();
    rom_mode = 1;
    wr(6'h24, 16'h00FF);
    wr(6'd6, 16'd90);
    wr(6'd7, 16'h9064);
    do_swap("prio");
    jump_row(99);
    wait_to(164, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== CYAN) begin
      failures++;
      $display("FAIL prio_col80: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, CYAN);
    end
    wait_to(171, 100);
    checks++;
    if (rom_addr !== 13'd5633) begin
      failures++;
      $display("FAIL prio_addr85: got %0d want 5633", rom_addr);
    end
    wait_to(174, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== LAND) begin
      failures++;
      $display("FAIL prio_transp85: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, LAND);
    end
    wait_to(193, 100);
    checks++;
    if (rom_addr !== 13'd5644) begin
      failures++;
      $display("FAIL prio_addr96: got %0d want 5644", rom_addr);
    end
    wait_to(196, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== RED) begin
      failures++;
      $display("FAIL prio_col96: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, RED);
    end
  endtask

  task automatic test_shadow();
    int cols [3] = '{100, 300, 400};
    logic [23:0] w0 [3] = '{RED, LAND, LAND};
    logic [23:0] w1 [3] = '{LAND, RED, LAND};
    logic [23:0] w2 [3] = '{LAND, LAND, RED};
    rom_mode = 0;
    jump_row(199);
    wait_to(0, 200);
    wr(6'd4, 16'd300);
    wr(6'd7, 16'h0000);
    jump_row(99);
    for (int i = 0; i < 3; i++) begin
      wait_to(2*cols[i] + 4, 100);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== w0[i]) begin
        failures++;
        $display("FAIL shadow_old_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, w0[i]);
      end
    end
    jump_row(479);
    wait_to(1599, 479);
    wr(6'd4, 16'd400);
    checks++;
    if (frame_irq !== 1'b1) begin
      failures++;
      $display("FAIL shadow_irq_on: got %b want 1", frame_irq);
    end
    tick();
    checks++;
    if (frame_irq !== 1'b0) begin
      failures++;
      $display("FAIL shadow_irq_off: got %b want 0", frame_irq);
    end
    jump_row(99);
    for (int i = 0; i < 3; i++) begin
      wait_to(2*cols[i] + 4, 100);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== w1[i]) begin
        failures++;
        $display("FAIL shadow_new_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, w1[i]);
      end
    end
    do_swap("shadow");
    jump_row(99);
    for (int i = 0; i < 3; i++) begin
      wait_to(2*cols[i] + 4, 100);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== w2[i]) begin
        failures++;
        $display("FAIL shadow_late_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, w2[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int cols [4] = '{199, 200, 399, 400};
    logic [23:0] want [4] = '{LAND, WATER, WATER, LAND};
    wr(6'd0, 16'd200);
    wr(6'd1, 16'd400);
    do_swap("bnd");
    jump_row(9);
    for (int i = 0; i < 4; i++) begin
      wait_to(2*cols[i] + 4, 10);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== want[i]) begin
        failures++;
        $display("FAIL bnd_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, want[i]);
      end
    end
    wr(6'h21, 16'h0CCC);
    wait_to(1004, 10);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hCCCCCC) begin
      failures++;
      $display("FAIL bnd_pal_now: got %h%h%h want cccccc",
               VGA_R, VGA_G, VGA_B);
    end
    wr(6'h21, 16'h00A0);
  endtask

  task automatic test_clip();
    int cols [3] = '{0, 5, 639};
    rom_mode = 0;
    wr(6'd4, 16'd5);
    do_swap("clip");
    jump_row(99);
    wait_to(1, 100);
    checks++;
    if (rom_addr !== 13'd5643) begin
      failures++;
      $display("FAIL clip_addr0: got %0d want 5643", rom_addr);
    end
    wait_to(4, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== RED) begin
      failures++;
      $display("FAIL clip_col0: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, RED);
    end
    wait_to(41, 100);
    checks++;
    if (rom_addr !== 13'd5663) begin
      failures++;
      $display("FAIL clip_addr20: got %0d want 5663", rom_addr);
    end
    wait_to(44, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== RED) begin
      failures++;
      $display("FAIL clip_col20: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, RED);
    end
    wait_to(46, 100);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== LAND) begin
      failures++;
      $display("FAIL clip_col21: got %h%h%h want %h",
               VGA_R, VGA_G, VGA_B, LAND);
    end
    wr(6'd4, 16'd1020);
    wr(6'h1F, 16'hFFFF);
    do_swap("clip_far");
    jump_row(99);
    for (int i = 0; i < 3; i++) begin
      wait_to(2*cols[i] + 4, 100);
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== LAND) begin
        failures++;
        $display("FAIL clip_far_col%0d: got %h%h%h want %h",
                 cols[i], VGA_R, VGA_G, VGA_B, LAND);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_shadow();
    test_boundary();
    test_clip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised raster compositor for the Water-Raid display path. It takes NUM_SPRITES movable sprites and a river background with NUM_BOUNDARIES land/water edges, written over Avalon-MM. It fetches sprite pixels from one shared external sprite ROM, resolves priority and transparency, maps colour indices through a CPU-writable palette, and drives the 640x480 VGA pins. Sprite and boundary registers are double-buffered and swap at vertical blank, so gameplay updates never tear mid-frame.

## Interface
Parameters:
- NUM_SPRITES, 8: sprite slots. Slot 0 has the highest priority.
- NUM_BOUNDARIES, 4: river edge registers. NUM_BOUNDARIES + 2*NUM_SPRITES must be ≤ 32.
- SPRITE_SIZE, 32: sprite edge length in pixels. Must be a power of two.
- NUM_IMAGES, 8: images stored in the sprite ROM.
- ADDR_W, 6: Avalon address width.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  reset, asynchronous, active-high
- chipselect, write  in  1  Avalon write strobe pair
- address  in  ADDR_W  register index
- writedata  in  16  write data
- rom_addr  out  log2(NUM_IMAGES·SIZE²)  sprite ROM address
- rom_q  in  4  colour index; the ROM is registered with 1-cycle latency
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1  VGA control
- frame_irq  out  1  one-clk pulse when the shadow bank is swapped

## Operation
Register map (writes only; writes to unmapped addresses are ignored):
- Addresses 0..NUM_BOUNDARIES-1: boundary k, writedata[9:0].
- Address NB+2i: sprite i X centre, [9:0].
- Address NB+2i+1: sprite i control. [9:0] is the Y centre, [14:12] is the image index, [15] is enable.
- Addresses 0x20..0x2F: palette entry n, RGB444 in [11:0].
  - Palette writes take effect immediately; the palette is not double-buffered.

Shadow banks:
- Boundary and sprite writes land in the pending bank.
- Pending is copied to the active bank on the clk where the counters reach hcount=0, vcount=480. frame_irq pulses on that same clk.
- A write on the copy cycle stays in pending and is not copied; the copy uses the pre-write value. It is copied at the next frame.

Background index, computed per column col:
- A boundary is inactive when its value is 0.
- The pixel is water (WATER_IDX=2) if an odd number of active boundaries satisfy col ≥ b_k; otherwise it is land (LAND_IDX=1).

Sprite hit:
- Compute dx = col − x + SIZE/2 and dy = row − y + SIZE/2 in 11-bit unsigned arithmetic. A hit requires enable=1, dx < SIZE and dy < SIZE.
- Negative values wrap to large numbers and miss, so sprites clip at every screen edge.
- When several sprites hit, the lowest-index hitting slot wins. rom_addr = image·SIZE² + dy·SIZE + dx.
- rom_q = 0 is transparent and shows the background, not lower-priority sprites. Otherwise rom_q is the colour index.

Output colour:
- Final index → palette → RGB444, with each nibble replicated to 8 bits (e.g. 0xA → 0xAA).
- RGB is 0 whenever the delayed blank is active.

## Timing
Pipeline: the counters are followed by four register stages.
- S1 registers rom_addr, the hit flag and the background index.
- S2 is the ROM output.
- S3 registers the selected colour index.
- S4 registers the palette lookup into VGA_R/G/B.
- RGB for counter value (h,v) appears exactly 4 clk after the counters hold (h,v).

Control signals:
- HS, VS, BLANK_n and VGA_CLK (hcount[0]) are decoded from the counters and delayed 4 clk to stay aligned with RGB.
- HS is active low at hcount 1312..1503. VS is active low on vcount 490..491.
- Timing is 1600x525 clk per frame; one pixel spans 2 clk.

Reset (asynchronous; the same applies when asserted mid-frame):
- Counters go to 0. All pipeline stages, both banks and the palette clear to 0.
- RGB=0, HS=1, VS=1, BLANK_n=0, VGA_CLK=0, frame_irq=0, rom_addr=0. VGA_SYNC_n is 0 constantly.
- On release, scanout restarts at (0,0) with all sprites disabled and an all-black palette.

## Structure
- Package sprite_compositor_pkg holds:
  - the rgb444_t and cidx_t typedefs
  - the VGA timing constants (HACTIVE, HTOTAL, VACTIVE, VTOTAL, sync start/end)
  - LAND_IDX and WATER_IDX
  - the register-map base constants
- One sub-module, raster_timing, holds the 1600x525 counters and the undelayed sync/blank decode.
- The top level holds the register banks, the hit/priority logic and the pipeline.

## Test plan
- Reset: assert reset mid-line → all outputs at their reset values within the same clk. After release, first HS low at hcount 1312+4.
- Single sprite: palette[3]=0xF00, sprite0 at X=100, Y=100, enabled, rom_q≡3, swap done.
  - Row 100, cols 84..115 → RGB FF/00/00.
  - Cols 83 and 116 → the land colour.
  - rom_addr at col 84, row 84 = image·1024.
- Priority and transparency:
  - Sprites 0 and 1 overlapping → rom_addr uses sprite 0's dx/dy.
  - rom_q=0 → background colour, not sprite 1.
- Shadow: write sprite0 X=300 at vcount 200 → display unchanged until the swap at vcount 480. frame_irq is high for exactly 1 clk. The new position appears in the next frame.
- Boundaries: b0=200, b1=400, b2=b3=0 → col 199 land, col 200 water, col 399 water, col 400 land.
- Clipping:
  - X=5 → cols 0..20 drawn with dx 11..31.
  - X=1020 → no hit anywhere on screen.
  - Write to address 0x1F → no state change.
